// File: rtl/calc_pkg.sv
// Shared key-code map, state encoding and operand arithmetic for the calculator entry block.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package calc_pkg;

    localparam int OPND_W = 7;

    // Full 4-bit keypad map: digits, three operators, no-op, equals, clear.
    typedef enum logic [3:0] {
        KEY_0   = 4'd0,
        KEY_1   = 4'd1,
        KEY_2   = 4'd2,
        KEY_3   = 4'd3,
        KEY_4   = 4'd4,
        KEY_5   = 4'd5,
        KEY_6   = 4'd6,
        KEY_7   = 4'd7,
        KEY_8   = 4'd8,
        KEY_9   = 4'd9,
        OP_ADD  = 4'd10,
        OP_SUB  = 4'd11,
        OP_MUL  = 4'd12,
        OP_NOP  = 4'd13,
        KEY_EQ  = 4'd14,
        KEY_CLR = 4'd15
    } key_t;

    // State encoding doubles as the phase seen by the display mux.
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= KEY_9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= OP_ADD) && (k <= OP_MUL);
    endfunction

    // Shift one decimal digit into an operand. The product is formed wide and
    // cut back to the operand width; with two digits it never exceeds 99.
    function automatic logic [OPND_W-1:0] acc_digit(input logic [OPND_W-1:0] v,
                                                     input logic [3:0]        d);
        logic [10:0] t;
        t = {4'd0, v} * 11'd10 + {7'd0, d};
        return t[OPND_W-1:0];
    endfunction

endpackage

// File: rtl/calc_entry_key_edge.sv
// Turns the level key_down into a single press pulse on its rising edge; re-arms only after key_down is seen low.
// Latency: combinational pulse, valid in the cycle key_down first reads high.
// Backpressure: none; a press is reported whether or not anyone acts on it.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_down,
    output logic press
);

    logic key_q;
    logic armed;

    // Previous key level, plus an arm flag so a key held across reset release
    // does not count until it has been let go once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            key_q <= key_down;
            armed <= armed | ~key_down;
        end
    end

    // Rising edge of the key level, gated by the arm flag.
    always_comb begin
        press = key_down & ~key_q & armed;
    end

endmodule

// File: rtl/calc_entry.sv
// Keypad entry FSM: builds two decimal operands, latches an operator and issues it on equals.
// Latency: every output reflects a press at the same clock edge that detects it (1 cycle from key rise).
// Backpressure: none; keys are consumed as pressed, illegal keys for the current state are dropped.
module calc_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key_code,
    input  logic              key_down,
    output logic [OPND_W-1:0] In1,
    output logic [OPND_W-1:0] In2,
    output logic [3:0]        keyboard,
    output logic              result_valid,
    output logic [1:0]        phase,
    output logic [OPND_W-1:0] disp_value
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [3:0]       op;
    logic             press;
    logic             k_digit;
    logic             k_op;

    key_edge u_key_edge (
        .clk      (clk),
        .rst      (rst),
        .key_down (key_down),
        .press    (press)
    );

    // Classify the key being sampled this cycle.
    always_comb begin
        k_digit = is_digit(key_code);
        k_op    = is_op(key_code);
    end

    // Entry state machine; operands, op, keyboard and result_valid all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ENTER_A;
            In1          <= '0;
            In2          <= '0;
            cnt1         <= '0;
            cnt2         <= '0;
            op           <= OP_NOP;
            keyboard     <= OP_NOP;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (press) begin
                if (key_code == KEY_CLR) begin
                    state    <= ENTER_A;
                    In1      <= '0;
                    In2      <= '0;
                    cnt1     <= '0;
                    cnt2     <= '0;
                    op       <= OP_NOP;
                    keyboard <= OP_NOP;
                end else begin
                    unique case (state)
                        ENTER_A: begin
                            if (k_digit) begin
                                if (cnt1 < CNT_MAX) begin
                                    In1  <= acc_digit(In1, key_code);
                                    cnt1 <= cnt1 + CNT_ONE;
                                end
                            end else if (k_op) begin
                                // An empty first operand is legal and reads as zero.
                                op    <= key_code;
                                In2   <= '0;
                                cnt2  <= '0;
                                state <= ENTER_B;
                            end
                        end
                        ENTER_B: begin
                            if (k_digit) begin
                                if (cnt2 < CNT_MAX) begin
                                    In2  <= acc_digit(In2, key_code);
                                    cnt2 <= cnt2 + CNT_ONE;
                                end
                            end else if (k_op) begin
                                // Operator may still be changed until In2 gets a digit.
                                if (cnt2 == '0) begin
                                    op <= key_code;
                                end
                            end else if (key_code == KEY_EQ) begin
                                if (cnt2 != '0) begin
                                    state        <= RESULT;
                                    keyboard     <= op;
                                    result_valid <= 1'b1;
                                end
                            end
                        end
                        RESULT: begin
                            // A digit starts a fresh calculation with that digit as In1.
                            if (k_digit) begin
                                In1      <= {{(OPND_W-4){1'b0}}, key_code};
                                cnt1     <= CNT_ONE;
                                In2      <= '0;
                                cnt2     <= '0;
                                state    <= ENTER_A;
                                keyboard <= OP_NOP;
                            end
                        end
                        default: begin
                            state    <= ENTER_A;
                            keyboard <= OP_NOP;
                        end
                    endcase
                end
            end
        end
    end

    // Phase mirrors the state; the display follows whichever operand is live.
    always_comb begin
        phase      = state;
        disp_value = (state == ENTER_A) ? In1 : In2;
    end

endmodule
